lcd_bus_receiver: RTL

- Panel-side responder for the 8080-style 8-bit LCD write bus: lcd_db, lcd_wr, lcd_d_c, lcd_rd, lcd_reset.
- Decodes the command/data byte stream (CASET, PASET, RAMWR, SWRESET, DISPON/DISPOFF) into addressed RGB565 pixel writes with window auto-increment.
- Used as a synthesizable panel model in the screen-controller bench and as a loopback checker on the Arduino header.

---
 rtl/lcd_bus_receiver.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_receiver.sv
// Panel-side responder for an 8080-style 8-bit LCD write bus: decodes CASET/PASET/RAMWR/
// SWRESET/DISPON/DISPOFF into addressed RGB565 pixel writes. Optional macro: LCD_RX_PROTO_ERR_EN.
module lcd_bus_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int H_RES       = 320,
  parameter int V_RES       = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  lcd_db,
  input  logic        lcd_wr,
  input  logic        lcd_d_c,
  input  logic        lcd_rd,
  input  logic        lcd_reset,
  output logic        pix_valid,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic [15:0] pix_rgb,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        disp_on,
  output logic        proto_err
);

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [15:0] EC_RST = 16'(H_RES - 1);
  localparam logic [15:0] EP_RST = 16'(V_RES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CASET, S_PASET, S_RAMWR_HI, S_RAMWR_LO, S_IGNORE
  } state_t;

  state_t state, state_next;

  logic [NS-1:0][7:0] db_sync;
  logic [NS-1:0]      wr_sync, dc_sync, lrst_sync;
  logic               wr_prev;
  logic [7:0]         db_s;
  logic               byte_evt, is_cmd, is_data, soft_rst;
  logic               unused_rd;

  logic [15:0] sc, ec, sp, ep, cur_x, cur_y;
  logic [23:0] win_buf;
  logic [1:0]  byte_idx;
  logic [7:0]  hi_byte;

  assign unused_rd = lcd_rd;

  // wr and lcd_reset sync flops reset to their idle-high level so release is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_sync   <= '0;
      dc_sync   <= '0;
      wr_sync   <= '1;
      lrst_sync <= '1;
      wr_prev   <= 1'b1;
    end else begin
      db_sync   <= {db_sync[NS-2:0], lcd_db};
      dc_sync   <= {dc_sync[NS-2:0], lcd_d_c};
      wr_sync   <= {wr_sync[NS-2:0], lcd_wr};
      lrst_sync <= {lrst_sync[NS-2:0], lcd_reset};
      wr_prev   <= wr_sync[NS-1];
    end
  end

  assign db_s     = db_sync[NS-1];
  assign byte_evt = wr_sync[NS-1] & ~wr_prev;
  assign is_cmd   = byte_evt & ~dc_sync[NS-1];
  assign is_data  = byte_evt & dc_sync[NS-1];
  assign soft_rst = ~lrst_sync[NS-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         state <= S_IDLE;
    else if (soft_rst) state <= S_IDLE;
    else               state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (is_cmd) begin
      case (db_s)
        8'h2A:               state_next = S_CASET;
        8'h2B:               state_next = S_PASET;
        8'h2C:               state_next = S_RAMWR_HI;
        8'h01, 8'h28, 8'h29: state_next = S_IDLE;
        default:             state_next = S_IGNORE;
      endcase
    end else if (is_data) begin
      case (state)
        S_CASET, S_PASET: if (byte_idx == 2'd3) state_next = S_IGNORE;
        S_RAMWR_HI:       state_next = S_RAMWR_LO;
        S_RAMWR_LO:       state_next = S_RAMWR_HI;
        default:          state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid <= 1'b0; pix_x <= '0; pix_y <= '0; pix_rgb <= '0;
      cmd_valid <= 1'b0; cmd_code <= '0; disp_on <= 1'b0;
      sc <= '0; ec <= EC_RST; sp <= '0; ep <= EP_RST;
      cur_x <= '0; cur_y <= '0; win_buf <= '0; byte_idx <= '0; hi_byte <= '0;
    end else if (soft_rst) begin
      pix_valid <= 1'b0; pix_x <= '0; pix_y <= '0; pix_rgb <= '0;
      cmd_valid <= 1'b0; cmd_code <= '0; disp_on <= 1'b0;
      sc <= '0; ec <= EC_RST; sp <= '0; ep <= EP_RST;
      cur_x <= '0; cur_y <= '0; win_buf <= '0; byte_idx <= '0; hi_byte <= '0;
    end else begin
      pix_valid <= 1'b0;
      cmd_valid <= 1'b0;
      if (is_cmd) begin
        cmd_valid <= 1'b1;
        cmd_code  <= db_s;
        byte_idx  <= '0;
        case (db_s)
          8'h2C: begin cur_x <= sc; cur_y <= sp; end
          8'h01: begin sc <= '0; ec <= EC_RST; sp <= '0; ep <= EP_RST; disp_on <= 1'b0; end
          8'h29: disp_on <= 1'b1;
          8'h28: disp_on <= 1'b0;
          default: ;
        endcase
      end else if (is_data) begin
        case (state)
          S_CASET, S_PASET: begin
            // window registers change only once all four parameter bytes are in
            byte_idx <= byte_idx + 2'd1;
            win_buf  <= {win_buf[15:0], db_s};
            if (byte_idx == 2'd3) begin
              if (state == S_CASET) {sc, ec} <= {win_buf, db_s};
              else                  {sp, ep} <= {win_buf, db_s};
            end
          end
          S_RAMWR_HI: hi_byte <= db_s;
          S_RAMWR_LO: begin
            pix_valid <= 1'b1;
            pix_x     <= cur_x;
            pix_y     <= cur_y;
            pix_rgb   <= {hi_byte, db_s};
            if (cur_x >= ec) begin
              cur_x <= sc;
              cur_y <= (cur_y >= ep) ? sp : cur_y + 16'd1;
            end else begin
              cur_x <= cur_x + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LCD_RX_PROTO_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         proto_err <= 1'b0;
    else if (soft_rst) proto_err <= 1'b0;
    else if ((is_data && state == S_IDLE) ||
             (is_cmd && (state == S_CASET || state == S_PASET || state == S_RAMWR_LO)))
      proto_err <= 1'b1;
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule
